// File: rtl/reg_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader.
// Optional checksum trailer: define REG_DUMP_CHECKSUM_EN.
package reg_dump_reader_pkg;

  localparam int NUM_REGS = 16;
  localparam int REG_W    = 8;
  localparam int IDX_W    = 4;

  localparam logic [IDX_W-1:0] CSUM_INDEX = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND_LO,
    SEND_HI,
`ifdef REG_DUMP_CHECKSUM_EN
    SEND_CSUM,
`endif
    DONE
  } dumpState_t;

  function automatic logic [IDX_W-1:0] topBit(
    input logic [NUM_REGS-1:0] m
  );
    topBit = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (m[i]) topBit = i[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/reg_dump_reader_if.sv
// Valid/ready byte stream carrying dumped register bytes.
// Shared by reg_dump_reader builds with or without REG_DUMP_CHECKSUM_EN.
interface reg_dump_reader_if;
  import reg_dump_reader_pkg::*;

  logic [REG_W-1:0] DumpData;
  logic [IDX_W-1:0] DumpIndex;
  logic             DumpValid;
  logic             DumpReady;
  logic             DumpLast;

  modport master (
    output DumpData,
    output DumpIndex,
    output DumpValid,
    output DumpLast,
    input  DumpReady
  );

  modport slave (
    input  DumpData,
    input  DumpIndex,
    input  DumpValid,
    input  DumpLast,
    output DumpReady
  );

endinterface

// File: rtl/reg_dump_reader.sv
// Walks the register file pairwise and streams masked bytes out.
// Define REG_DUMP_CHECKSUM_EN to append an XOR checksum byte.
module reg_dump_reader
  import reg_dump_reader_pkg::*;
(
  input  logic                CLK,
  input  logic                init,
  input  logic                Start,
  input  logic [NUM_REGS-1:0] Mask,
  output logic [IDX_W-1:0]    RegSrc1,
  output logic [IDX_W-1:0]    RegSrc2,
  input  logic [REG_W-1:0]    Out1,
  input  logic [REG_W-1:0]    Out2,
  reg_dump_reader_if.master   dump,
  output logic                Busy,
  output logic                Done
);

  dumpState_t          state;
  logic [NUM_REGS-1:0] maskQ;
  logic [2:0]          p;
  logic [REG_W-1:0]    lo;
  logic [REG_W-1:0]    hi;
  logic                mHi;
  logic [IDX_W-1:0]    lastIdx;

`ifdef REG_DUMP_CHECKSUM_EN
  logic [REG_W-1:0] csum;
  localparam dumpState_t TAIL = SEND_CSUM;
`else
  localparam dumpState_t TAIL = DONE;
`endif

  logic fire;
  logic lastPair;
  logic [IDX_W-1:0] evenIdx;
  logic [IDX_W-1:0] oddIdx;

  assign fire     = dump.DumpValid && dump.DumpReady;
  assign lastPair = (p == 3'd7);
  assign evenIdx  = {p, 1'b0};
  assign oddIdx   = {p, 1'b1};

  always_ff @(posedge CLK) begin
    if (init) begin
      state   <= IDLE;
      maskQ   <= '0;
      p       <= '0;
      lo      <= '0;
      hi      <= '0;
      mHi     <= 1'b0;
      lastIdx <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum    <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (Start) begin
            maskQ   <= Mask;
            lastIdx <= topBit(Mask);
            p       <= '0;
            state   <= FETCH;
`ifdef REG_DUMP_CHECKSUM_EN
            csum    <= '0;
`endif
          end
        end
        FETCH: begin
          lo  <= Out1;
          hi  <= Out2;
          mHi <= maskQ[oddIdx];
          if (maskQ[evenIdx])
            state <= SEND_LO;
          else if (maskQ[oddIdx])
            state <= SEND_HI;
          else if (lastPair)
            state <= TAIL;
          else
            p <= p + 3'd1;
        end
        SEND_LO: begin
          if (fire) begin
`ifdef REG_DUMP_CHECKSUM_EN
            csum <= csum ^ lo;
`endif
            if (mHi) begin
              state <= SEND_HI;
            end else if (lastPair) begin
              state <= TAIL;
            end else begin
              p     <= p + 3'd1;
              state <= FETCH;
            end
          end
        end
        SEND_HI: begin
          if (fire) begin
`ifdef REG_DUMP_CHECKSUM_EN
            csum <= csum ^ hi;
`endif
            if (lastPair) begin
              state <= TAIL;
            end else begin
              p     <= p + 3'd1;
              state <= FETCH;
            end
          end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        SEND_CSUM: begin
          if (fire) state <= DONE;
        end
`endif
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode only registered state, so they hold while stalled.
  always_comb begin
    RegSrc1        = '0;
    RegSrc2        = '0;
    dump.DumpData  = '0;
    dump.DumpIndex = '0;
    dump.DumpValid = 1'b0;
    dump.DumpLast  = 1'b0;
    unique case (state)
      FETCH: begin
        RegSrc1 = evenIdx;
        RegSrc2 = oddIdx;
      end
      SEND_LO: begin
        dump.DumpValid = 1'b1;
        dump.DumpData  = lo;
        dump.DumpIndex = evenIdx;
`ifndef REG_DUMP_CHECKSUM_EN
        dump.DumpLast  = (evenIdx == lastIdx);
`endif
      end
      SEND_HI: begin
        dump.DumpValid = 1'b1;
        dump.DumpData  = hi;
        dump.DumpIndex = oddIdx;
`ifndef REG_DUMP_CHECKSUM_EN
        dump.DumpLast  = (oddIdx == lastIdx);
`endif
      end
`ifdef REG_DUMP_CHECKSUM_EN
      SEND_CSUM: begin
        dump.DumpValid = 1'b1;
        dump.DumpData  = csum;
        dump.DumpIndex = CSUM_INDEX;
        dump.DumpLast  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign Busy = (state != IDLE);
  assign Done = (state == DONE);

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench for reg_dump_reader.
// Expectations adapt when REG_DUMP_CHECKSUM_EN is defined.
module tb_reg_dump_reader;

`ifdef REG_DUMP_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] idx;
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic        CLK;
  logic        init;
  logic        Start;
  logic [15:0] Mask;
  logic [3:0]  RegSrc1;
  logic [3:0]  RegSrc2;
  logic [7:0]  Out1;
  logic [7:0]  Out2;
  logic        Busy;
  logic        Done;
  logic [7:0]  R [16];

  reg_dump_reader_if dumpIf ();

  reg_dump_reader dut (
    .CLK     (CLK),
    .init    (init),
    .Start   (Start),
    .Mask    (Mask),
    .RegSrc1 (RegSrc1),
    .RegSrc2 (RegSrc2),
    .Out1    (Out1),
    .Out2    (Out2),
    .dump    (dumpIf),
    .Busy    (Busy),
    .Done    (Done)
  );

  assign Out1 = R[RegSrc1];
  assign Out2 = R[RegSrc2];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  exp_t sb [$];
  int   nv;
  int   nerr;

  task automatic load_regs();
    for (int i = 0; i < 16; i++) R[i] = 8'(i * 3);
  endtask

  task automatic check_idle(input string tag);
    nv++;
    if ({Busy, Done, dumpIf.DumpValid, dumpIf.DumpLast,
         dumpIf.DumpData, dumpIf.DumpIndex,
         RegSrc1, RegSrc2} !== 25'd0) begin
      nerr++;
      $display("FAIL %s: busy=%b done=%b v=%b l=%b d=%h i=%h rs=%h/%h want all 0",
               tag, Busy, Done, dumpIf.DumpValid, dumpIf.DumpLast,
               dumpIf.DumpData, dumpIf.DumpIndex, RegSrc1, RegSrc2);
    end
  endtask

  // Runs one dump: pushes the expected bytes, then pops them as the DUT emits.
  task automatic run_dump(input logic [15:0] m, input bit toggle,
                          input int againAt, input int initAt,
                          input string tag);
    exp_t e;
    exp_t got;
    exp_t held;
    int   cyc;
    int   top;
    int   nb;
    int   expDone;
    bit   fin;
    bit   pv;
    logic [7:0] x;
    top = -1;
    nb  = 0;
    x   = 8'h00;
    for (int i = 0; i < 16; i++) if (m[i]) top = i;
    for (int i = 0; i < 16; i++) begin
      if (m[i]) begin
        sb.push_back('{idx: i[3:0], data: R[i], last: (i == top) && !CSUM});
        x ^= R[i];
        nb++;
      end
    end
    if (CSUM) sb.push_back('{idx: 4'hF, data: x, last: 1'b1});
    expDone = 9 + nb + int'(CSUM);
    Mask  = m;
    Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    Mask  = 16'h0;
    cyc = 1;
    fin = 1'b0;
    pv  = 1'b0;
    held = '0;
    while (!fin) begin
      dumpIf.DumpReady = toggle ? cyc[0] : 1'b1;
      Start = (cyc == againAt);
      if (cyc == initAt) begin
        init = 1'b1;
        dumpIf.DumpReady = 1'b0;
      end
      @(negedge CLK);
      got = '{dumpIf.DumpIndex, dumpIf.DumpData, dumpIf.DumpLast};
      if (cyc == 1) begin
        nv++;
        if (Busy !== 1'b1) begin
          nerr++;
          $display("FAIL %s busy: got %b want 1", tag, Busy);
        end
      end
      if (pv) begin
        nv++;
        if (got !== held || dumpIf.DumpValid !== 1'b1) begin
          nerr++;
          $display("FAIL %s hold: got %h v=%b want %h", tag, got,
                   dumpIf.DumpValid, held);
        end
      end
      pv = 1'b0;
      if (dumpIf.DumpValid === 1'b1) begin
        if (dumpIf.DumpReady !== 1'b1) begin
          pv   = 1'b1;
          held = got;
        end else begin
          nv++;
          if (sb.size() == 0) begin
            nerr++;
            $display("FAIL %s extra byte: got %h want none", tag, got);
          end else begin
            e = sb.pop_front();
            if (got !== e) begin
              nerr++;
              $display("FAIL %s byte: got idx=%h d=%h l=%b want idx=%h d=%h l=%b",
                       tag, got.idx, got.data, got.last, e.idx, e.data, e.last);
            end
          end
        end
      end
      if (Done === 1'b1) begin
        fin = 1'b1;
        nv++;
        if (!toggle && initAt == 0 && cyc != expDone) begin
          nerr++;
          $display("FAIL %s done cycle: got %0d want %0d", tag, cyc, expDone);
        end
        nv++;
        if (sb.size() != 0) begin
          nerr++;
          $display("FAIL %s leftover: got %0d pending want 0", tag, sb.size());
        end
      end
      @(posedge CLK); #1;
      Start = 1'b0;
      if (cyc == initAt) begin
        init = 1'b0;
        sb.delete();
        fin = 1'b1;
      end
      cyc++;
      if (!fin && cyc > 400) begin
        nerr++;
        $display("FAIL %s timeout: got no Done want Done", tag);
        fin = 1'b1;
      end
    end
    check_idle({tag, " end"});
    dumpIf.DumpReady = 1'b1;
  endtask

  task automatic test_reset();
    init = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check_idle("reset");
    init = 1'b0;
  endtask

  task automatic test_full_mask();
    run_dump(16'hFFFF, 1'b0, 0, 0, "full");
  endtask

  task automatic test_stall_sparse();
    run_dump(16'h8001, 1'b1, 0, 0, "stall");
  endtask

  task automatic test_empty_mask();
    run_dump(16'h0000, 1'b0, 0, 0, "empty");
  endtask

  task automatic test_start_while_busy();
    run_dump(16'hFFFF, 1'b0, 5, 0, "restart");
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      nv++;
      if (Done !== 1'b0 || Busy !== 1'b0 || dumpIf.DumpValid !== 1'b0) begin
        nerr++;
        $display("FAIL restart quiet: got done=%b busy=%b v=%b want 0",
                 Done, Busy, dumpIf.DumpValid);
      end
    end
  endtask

  task automatic test_init_mid_dump();
    run_dump(16'hFFFF, 1'b0, 0, 12, "initmid");
    run_dump(16'hFFFF, 1'b0, 0, 0, "after init");
  endtask

  task automatic test_pair_bytes();
    R[1] = 8'hA5;
    R[2] = 8'h0F;
    run_dump(16'h0006, 1'b0, 0, 0, "pair");
    load_regs();
  endtask

  initial begin
    nv    = 0;
    nerr  = 0;
    init  = 1'b1;
    Start = 1'b0;
    Mask  = 16'h0;
    dumpIf.DumpReady = 1'b1;
    load_regs();
    test_reset();
    test_full_mask();
    test_stall_sparse();
    test_empty_mask();
    test_start_while_busy();
    test_init_mid_dump();
    test_pair_bytes();
    $display("== %0d vectors applied, %0d miscompares ==", nv, nerr);
    $finish;
  end

endmodule

// File: doc/reg_dump_reader.md
# reg_dump_reader

Debug/readout engine on the read side of the 16×8 register file. On a start pulse it walks the register file pair by pair through the two combinational read ports. It streams the selected register bytes out over a valid/ready byte interface. It sits beside the core datapath and borrows the read-port address lines only while busy; the core muxes them.

## Interface
Parameters:
- none; register count (16) and width (8) come from the shared package.

Ports:
- CLK  input  1  clock, all state changes on posedge.
- init  input  1  reset, synchronous, active-high.
- Start  input  1  begin dump; sampled only in IDLE.
- Mask  input  16  bit i = emit register i; captured on accepted Start.
- RegSrc1  output  4  read address, port 1 (even register of pair).
- RegSrc2  output  4  read address, port 2 (odd register of pair).
- Out1  input  8  register file read data, port 1 (combinational, same cycle).
- Out2  input  8  register file read data, port 2.
- DumpData  output  8  streamed byte.
- DumpIndex  output  4  register number of DumpData.
- DumpValid  output  1  DumpData/DumpIndex/DumpLast valid.
- DumpReady  input  1  sink accepts byte when DumpValid && DumpReady.
- DumpLast  output  1  marks final byte of the dump.
- Busy  output  1  high from the cycle after accepted Start through the DONE cycle.
- Done  output  1  one-cycle pulse at end of dump.

## Operation
- States: IDLE, FETCH, SEND_LO, SEND_HI, DONE.
- IDLE: RegSrc1=0, RegSrc2=0, all outputs low. On Start, latch Mask, pair pointer p=0, go FETCH. Start is ignored in any other state.
- FETCH: drive RegSrc1=2p, RegSrc2=2p+1. At clock edge, latch Out1→lo, Out2→hi, and mask bits m_lo/m_hi.
  - If m_lo, go SEND_LO.
  - Else if m_hi, go SEND_HI.
  - Else if p==7, go DONE.
  - Else p++ and stay in FETCH.
- SEND_LO: DumpValid=1, DumpData=lo, DumpIndex=2p. On handshake, go SEND_HI if m_hi, else advance as below.
- SEND_HI: same behaviour with hi, 2p+1.
- Advance: if p==7, go DONE; else p++, go FETCH.
- DONE: Done=1 for one cycle, then IDLE.
- DumpLast is high on the byte whose index is the highest set bit of the latched Mask. The checksum option overrides this.
- Reads are not atomic. Register-file writes during a dump are visible if they land before the pair is fetched.
- Mask==0: the block scans all 8 pairs with no DumpValid, then Done. Done comes 9 cycles after Start.
- While DumpValid=1 && DumpReady=0, DumpData, DumpIndex and DumpLast hold stable.

## Timing
- Start is sampled in cycle 0. FETCH of pair 0 is cycle 1, with Busy=1. The first DumpValid is in cycle 2.
- Each unmasked pair costs 1 cycle. Each emitted byte costs ≥1 cycle, exactly 1 with DumpReady held high.
- Full mask with DumpReady=1: 8 FETCH + 16 SEND + 1 DONE. Done is in cycle 25.
- Reset values: state IDLE, RegSrc1=RegSrc2=0, DumpData=0, DumpIndex=0, DumpValid=0, DumpLast=0, Busy=0, Done=0, checksum=0.
- init mid-dump: the next cycle is IDLE with all outputs at reset values. No Done pulse. A pending byte is dropped.
- init and Start in the same cycle: init wins.

## Configuration
- REG_DUMP_CHECKSUM_EN defined:
  - The block XORs every emitted byte into a checksum.
  - After pair 7 it enters a SEND_CSUM state: DumpData=checksum, DumpIndex=4'hF, DumpLast=1. The normal register bytes never assert DumpLast.
  - Mask==0 still emits checksum 0x00.
  - DONE follows the checksum handshake.
- Undefined: no SEND_CSUM state and no checksum register. DumpLast works as in Operation.

## Structure
- Shared definitions package holds:
  - the dump state enum;
  - the register count and width constants (NUM_REGS=16, REG_W=8);
  - the checksum index constant (CSUM_INDEX=4'hF).
- Single module. No sub-module needed; the FSM and the byte buffer are small enough to stay inline.

## Test plan
- Mask=16'hFFFF, R[i]=i*3, DumpReady=1: 16 bytes with index 0..15, data 0,3,…,45. DumpLast on index 15. Done in cycle 25.
- Mask=16'h8001, DumpReady toggling 1/0: only indices 0 and 15 are emitted. Data holds stable while stalled. DumpLast on 15.
- Mask=0: no DumpValid. Done 9 cycles after Start. With REG_DUMP_CHECKSUM_EN, one byte 0x00 at index F with DumpLast.
- Start pulsed again while Busy: ignored. Exactly one dump and one Done.
- init asserted during SEND_HI of pair 3: next cycle all outputs zero, no Done. A new Start gives a full restart from index 0.
- REG_DUMP_CHECKSUM_EN, Mask=16'h0006, R1=8'hA5, R2=8'h0F: bytes A5, 0F, then checksum AA at index F with DumpLast.
